// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM encoding, address/word geometry and the word-alignment helper.
package fetch_pkg;

    localparam int ADDR_W        = 8;
    localparam int WORD_BYTES    = 4;
    localparam int FETCH_LATENCY = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_assembler.sv
// Four-byte instruction capture register, big-endian: byte k lands in word[31-8k -: 8].
// Each byte has its own load enable; clear wipes a partial or held word.
module inst_assembler
    import fetch_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [WORD_BYTES-1:0]   load_en,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word
);

    logic [8*WORD_BYTES-1:0] word_r;

    // Capture register with reset, clear and per-byte loads.
    always_ff @(posedge clock) begin
        if (reset) begin
            word_r <= 32'h0000_0000;
        end else if (clear) begin
            word_r <= 32'h0000_0000;
        end else begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (load_en[k]) begin
                    word_r[8*(WORD_BYTES-1-k) +: 8] <= byte_in;
                end
            end
        end
    end

    assign word = word_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: issues four byte reads, assembles a 32-bit word,
// and holds it for the consumer; redirects restart fetching at an aligned target.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [7:0]  mem_address,
    output logic        mem_read,
    input  logic [7:0]  mem_data,
    input  logic        redirect,
    input  logic [7:0]  redirect_target,
    output logic [31:0] instruction,
    output logic [7:0]  inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    fetch_state_t    state_r, state_s;
    logic [7:0]      pc_r, pc_s;
    logic [1:0]      byte_cnt_r, byte_cnt_s;
    logic            inst_valid_r, inst_valid_s;
    logic [7:0]      inst_pc_r, inst_pc_s;
    logic            mem_read_r, mem_read_s;
    logic [7:0]      mem_address_r, mem_address_s;
    logic            cap_valid_r;
    logic [1:0]      cap_idx_r;
    logic            flush_s;
    logic [WORD_BYTES-1:0] load_en_s;

    // Next-state, pc and next-output computation; redirect outranks every state.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        byte_cnt_s   = byte_cnt_r;
        inst_valid_s = inst_valid_r;
        inst_pc_s    = inst_pc_r;
        flush_s      = 1'b0;
        if (redirect) begin
            pc_s         = word_align(redirect_target);
            byte_cnt_s   = 2'd0;
            inst_valid_s = 1'b0;
            flush_s      = 1'b1;
            state_s      = enable ? ST_ISSUE : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    byte_cnt_s = 2'd0;
                    if (enable) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    byte_cnt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'(WORD_BYTES - 1)) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    byte_cnt_s   = 2'd0;
                    inst_valid_s = 1'b1;
                    inst_pc_s    = pc_r;
                    state_s      = ST_HOLD;
                end
                ST_HOLD: begin
                    byte_cnt_s = 2'd0;
                    if (inst_valid_r && inst_ready) begin
                        pc_s         = pc_r + 8'(WORD_BYTES);
                        inst_valid_s = 1'b0;
                        state_s      = enable ? ST_ISSUE : ST_IDLE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    byte_cnt_s   = 2'd0;
                    inst_valid_s = 1'b0;
                    state_s      = ST_IDLE;
                end
            endcase
        end
        // Address outputs are registered from next-state values so they line up with the state.
        mem_read_s = (state_s == ST_ISSUE);
        if (mem_read_s) begin
            mem_address_s = pc_s + {6'b00_0000, byte_cnt_s};
        end else begin
            mem_address_s = pc_s;
        end
    end

    // A byte is written only if its read was issued last cycle and nothing flushed it since.
    always_comb begin
        load_en_s = 4'b0000;
        if (cap_valid_r) begin
            load_en_s = 4'b0001 << cap_idx_r;
        end else begin
            load_en_s = 4'b0000;
        end
    end

    // State, pc, capture tracking and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            byte_cnt_r    <= 2'd0;
            inst_valid_r  <= 1'b0;
            inst_pc_r     <= RESET_PC;
            mem_read_r    <= 1'b0;
            mem_address_r <= RESET_PC;
            cap_valid_r   <= 1'b0;
            cap_idx_r     <= 2'd0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            byte_cnt_r    <= byte_cnt_s;
            inst_valid_r  <= inst_valid_s;
            inst_pc_r     <= inst_pc_s;
            mem_read_r    <= mem_read_s;
            mem_address_r <= mem_address_s;
            cap_valid_r   <= mem_read_r & ~redirect;
            cap_idx_r     <= byte_cnt_r;
        end
    end

    inst_assembler u_assembler (
        .clock   (clock),
        .reset   (reset),
        .clear   (flush_s),
        .load_en (load_en_s),
        .byte_in (mem_data),
        .word    (instruction)
    );

    assign mem_address = mem_address_r;
    assign mem_read    = mem_read_r;
    assign inst_pc     = inst_pc_r;
    assign inst_valid  = inst_valid_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: random memory image, directed fetch,
// stall, wrap, redirect and reset scenarios against a word-level reference model.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  mem_address;
    logic        mem_read;
    logic [7:0]  mem_data = 8'h00;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic [31:0] instruction;
    logic [7:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    logic [7:0]  mem [256];
    logic [7:0]  model_pc;
    int          tests_run = 0;
    int          tests_failed = 0;

    fetch_sequencer #(.RESET_PC(8'h00)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_data        (mem_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instruction     (instruction),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready)
    );

    always #5 clock = ~clock;

    // Memory responder: a byte appears the cycle after its read; garbage otherwise.
    always @(posedge clock) begin
        mem_data <= mem_read ? mem[mem_address] : 8'($urandom);
    end

    function automatic logic [31:0] expected_word(input logic [7:0] pc);
        logic [7:0] a1, a2, a3;
        a1 = pc + 8'd1;
        a2 = pc + 8'd2;
        a3 = pc + 8'd3;
        return {mem[pc], mem[a1], mem[a2], mem[a3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expects a complete fetch of the word at pc, ending with the word held.
    task automatic issue_and_check(input logic [7:0] pc, input bit toggle_enable);
        logic [7:0] a;
        for (int i = 0; i < 8 && !mem_read; i++) tick();
        check("first_read", {31'd0, mem_read}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            a = pc + 8'(k);
            check("issue_read", {31'd0, mem_read}, 32'd1);
            check("issue_addr", {24'd0, mem_address}, {24'd0, a});
            check("issue_valid_low", {31'd0, inst_valid}, 32'd0);
            if (toggle_enable) enable = 1'($urandom);
            tick();
        end
        check("drain_read", {31'd0, mem_read}, 32'd0);
        check("drain_addr", {24'd0, mem_address}, {24'd0, pc});
        check("drain_valid_low", {31'd0, inst_valid}, 32'd0);
        tick();
        check("valid_rise", {31'd0, inst_valid}, 32'd1);
        check("instruction", instruction, expected_word(pc));
        check("inst_pc", {24'd0, inst_pc}, {24'd0, pc});
        check("hold_read", {31'd0, mem_read}, 32'd0);
    endtask

    task automatic hold_check(input int n);
        logic [31:0] w;
        logic [7:0]  p;
        w = expected_word(model_pc);
        p = model_pc;
        inst_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check("stall_instruction", instruction, w);
            check("stall_inst_pc", {24'd0, inst_pc}, {24'd0, p});
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_no_read", {31'd0, mem_read}, 32'd0);
        end
    endtask

    task automatic handshake(input bit en);
        inst_ready = 1'b1;
        enable = en;
        tick();
        inst_ready = 1'b0;
        model_pc = model_pc + 8'd4;
        check("accept_valid_drop", {31'd0, inst_valid}, 32'd0);
        if (en) begin
            check("accept_next_read", {31'd0, mem_read}, 32'd1);
            check("accept_next_addr", {24'd0, mem_address}, {24'd0, model_pc});
        end else begin
            check("idle_read", {31'd0, mem_read}, 32'd0);
            check("idle_addr", {24'd0, mem_address}, {24'd0, model_pc});
            tick();
            check("idle_stays", {31'd0, mem_read}, 32'd0);
            enable = 1'b1;
        end
    endtask

    task automatic do_redirect(input logic [7:0] tgt, input bit ready);
        redirect = 1'b1;
        redirect_target = tgt;
        inst_ready = ready;
        enable = 1'b1;
        tick();
        redirect = 1'b0;
        inst_ready = 1'b0;
        model_pc = {tgt[7:2], 2'b00};
        check("redir_valid_low", {31'd0, inst_valid}, 32'd0);
        check("redir_read", {31'd0, mem_read}, 32'd1);
        check("redir_addr", {24'd0, mem_address}, {24'd0, model_pc});
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        redirect = 1'b0;
        redirect_target = 8'h00;
        inst_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
        tick(); tick(); tick();
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_read", {31'd0, mem_read}, 32'd0);
        check("rst_addr", {24'd0, mem_address}, 32'h00);
        check("rst_inst_pc", {24'd0, inst_pc}, 32'h00);
        check("rst_instruction", instruction, 32'h0);
        reset = 1'b0;
        model_pc = 8'h00;

        // First fetch, long stall, then sequential fetch.
        enable = 1'b1;
        issue_and_check(8'h00, 1'b0);
        check("first_word", instruction, 32'h8C01_0004);
        hold_check(10);
        handshake(1'b1);
        issue_and_check(model_pc, 1'b0);

        // Random stalls, enable drops mid-fetch and idle gaps.
        for (int r = 0; r < 6; r++) begin
            hold_check($urandom_range(0, 4));
            handshake(1'($urandom));
            issue_and_check(model_pc, 1'b1);
        end

        // Wrap from FC to 00.
        do_redirect(8'hFE, 1'b0);
        issue_and_check(8'hFC, 1'b0);
        handshake(1'b1);
        check("wrap_pc", {24'd0, model_pc}, 32'h00);
        issue_and_check(model_pc, 1'b0);

        // Redirect during ISSUE k=2.
        handshake(1'b1);
        tick(); tick();
        check("k2_addr", {24'd0, mem_address}, {24'd0, model_pc + 8'd2});
        do_redirect(8'h23, 1'b0);
        issue_and_check(8'h20, 1'b0);

        // Redirect coinciding with handshake.
        do_redirect(8'h40, 1'b1);
        issue_and_check(8'h40, 1'b0);

        // Random redirects in HOLD or mid-ISSUE.
        for (int r = 0; r < 5; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                handshake(1'b1);
                for (int t = 0; t < int'($urandom_range(0, 3)); t++) tick();
                do_redirect(8'($urandom), 1'b0);
            end else begin
                do_redirect(8'($urandom), 1'($urandom));
            end
            issue_and_check(model_pc, 1'b1);
        end

        // Reset during DRAIN.
        handshake(1'b1);
        tick(); tick(); tick(); tick();
        check("pre_rst_drain", {31'd0, mem_read}, 32'd0);
        reset = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        check("drst_valid", {31'd0, inst_valid}, 32'd0);
        check("drst_read", {31'd0, mem_read}, 32'd0);
        check("drst_addr", {24'd0, mem_address}, 32'h00);
        check("drst_instruction", instruction, 32'h0);
        tick(); tick(); tick();
        check("drst_idle_read", {31'd0, mem_read}, 32'd0);
        check("drst_late_byte", instruction, 32'h0);
        model_pc = 8'h00;
        enable = 1'b1;
        issue_and_check(8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clock and reset.
REQ-002 Parameter RESET_PC SHALL default to 8'h00 and SHALL be the fetch address loaded on reset.
REQ-003 Port clock, input, 1 bit: rising-edge clock for all state.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit: fetch permitted.
REQ-006 Port mem_address, output, 8 bits: byte address to the 256-byte instruction memory.
REQ-007 Port mem_read, output, 1 bit: read strobe for mem_address.
REQ-008 Port mem_data, input, 8 bits: memory byte, valid the cycle after its mem_read.
REQ-009 Port redirect, input, 1 bit: branch/jump redirect request.
REQ-010 Port redirect_target, input, 8 bits: new fetch byte address.
REQ-011 Port instruction, output, 32 bits: assembled instruction word.
REQ-012 Port inst_pc, output, 8 bits: byte address of the instruction's first byte.
REQ-013 Port inst_valid, output, 1 bit: instruction and inst_pc are valid.
REQ-014 Port inst_ready, input, 1 bit: consumer accepts the instruction.

Function
REQ-015 States SHALL be IDLE, ISSUE, DRAIN and HOLD.
REQ-016 IDLE SHALL transition to ISSUE on enable=1, otherwise stay in IDLE.
REQ-017 ISSUE SHALL last 4 cycles, driving mem_read=1 and mem_address=pc+k for k=0..3 from a 2-bit byte counter.
REQ-018 After ISSUE, the module SHALL enter DRAIN for 1 cycle to capture the last byte.
REQ-019 The module SHALL capture each byte the cycle after its issue, big-endian: byte k to instruction[31-8k -: 8].
REQ-020 inst_valid SHALL rise on the edge ending DRAIN, 5 cycles after the first issue, and the module SHALL enter HOLD.
REQ-021 In HOLD, instruction, inst_pc and inst_valid SHALL stay stable until inst_valid & inst_ready.
REQ-022 On a HOLD handshake, pc SHALL advance by 4 and inst_valid SHALL drop next cycle.
REQ-023 After a HOLD handshake, the next state SHALL be ISSUE if enable=1, else IDLE.
REQ-024 Address arithmetic SHALL be modulo 256: pc=8'hFC advances to 8'h00, and byte k of pc=8'hFE reads address (8'hFE+k) mod 256.
REQ-025 enable falling mid-ISSUE or mid-DRAIN SHALL NOT abort the fetch; the instruction SHALL complete and be held.
REQ-026 redirect=1 in any state SHALL take priority over all other transitions.
REQ-027 On redirect, pc SHALL load {redirect_target[7:2],2'b00}, discard any partial or held instruction, clear inst_valid next cycle, and enter ISSUE if enable=1, else IDLE.
REQ-028 A byte returning the cycle after a redirect SHALL be ignored.
REQ-029 A redirect coinciding with a HOLD handshake SHALL count the held instruction as consumed, and redirect SHALL set pc; no double advance SHALL occur.
REQ-030 mem_read SHALL be 0 in IDLE, DRAIN and HOLD.
REQ-031 mem_address SHALL equal pc whenever mem_read=0.

Reset
REQ-032 When reset=1 at a rising edge, state SHALL become IDLE, pc SHALL become RESET_PC, and the byte counter SHALL become 0.
REQ-033 When reset=1 at a rising edge, outputs SHALL become instruction=0, inst_pc=RESET_PC, inst_valid=0 and mem_read=0.
REQ-034 Reset SHALL override redirect and any in-flight fetch; a byte returning after reset SHALL be ignored.

Structure
REQ-035 Package fetch_pkg SHALL hold the state encoding, ADDR_W=8, WORD_BYTES=4 and FETCH_LATENCY=5.
REQ-036 Sub-module inst_assembler SHALL hold the 4-byte capture register with per-byte load enables and a clear input.

Verification
REQ-037 Reset then enable=1, memory bytes 0..3 = 8C,01,00,04, inst_ready=1 -> addresses 00,01,02,03 issued; instruction=32'h8C010004, inst_pc=00, inst_valid exactly 5 cycles after the first mem_read.
REQ-038 inst_ready=0 for 10 cycles in HOLD -> instruction, inst_pc and inst_valid stable; no mem_read; after ready, the next fetch starts at 04.
REQ-039 pc=FC, ready=1 -> instruction from FC..FF, then the next inst_pc=00.
REQ-040 redirect=1 with target=8'h23 during ISSUE k=2 -> no inst_valid for the old pc; next issues 20,21,22,23; inst_pc=20.
REQ-041 redirect together with a HOLD handshake, target=40 -> the held instruction is accepted once; the next inst_pc=40, not pc+4.
REQ-042 reset asserted mid-DRAIN -> next cycle inst_valid=0, mem_read=0, state IDLE; the next fetch after enable starts at RESET_PC.
